// File: rtl/controle_rodada_pkg.sv
// Shared types and constants for the werewolf round sequencer.
package controle_rodada_pkg;

   localparam int N_JOG = 5;
   localparam logic [2:0] ALVO_ABSTEM = 3'd7;

   // Phase code shown on the fase output.
   typedef enum logic [1:0] {
      FASE_IDLE  = 2'd0,
      FASE_NOITE = 2'd1,
      FASE_DIA   = 2'd2,
      FASE_FIM   = 2'd3
   } fase_t;

   // Internal controller state; CHECK never appears on fase.
   typedef enum logic [2:0] {
      EST_IDLE  = 3'd0,
      EST_NOITE = 3'd1,
      EST_DIA   = 3'd2,
      EST_CHECK = 3'd3,
      EST_FIM   = 3'd4
   } estado_t;

   typedef enum logic [1:0] {
      VENC_NENHUM = 2'd0,
      VENC_ALDEIA = 2'd1,
      VENC_LOBOS  = 2'd2
   } vencedor_t;

   // True when a presented target must be refused in the current phase.
   function automatic logic alvo_rejeitado(input logic [2:0] alvo,
                                           input logic       noite,
                                           input logic [4:0] mortos,
                                           input logic [4:0] lobos);
      logic       rej;
      logic [7:0] mortos8;
      logic [7:0] lobos8;
      mortos8 = {3'b000, mortos};
      lobos8  = {3'b000, lobos};
      rej     = 1'b0;
      if (alvo == 3'd5 || alvo == 3'd6) begin
         rej = 1'b1;
      end else if (alvo == ALVO_ABSTEM) begin
         // Abstaining is only a day-vote option; wolves must kill at night.
         rej = noite;
      end else if (mortos8[alvo]) begin
         rej = 1'b1;
      end else if (noite && lobos8[alvo]) begin
         rej = 1'b1;
      end
      return rej;
   endfunction

endpackage

// File: rtl/controle_rodada_conta.sv
// conta_mortes: 5-bit population counter, used for the dead count and for
// counting living wolves and living villagers.
module conta_mortes
   import controle_rodada_pkg::*;
(
   input  logic [4:0] bits,
   output logic [2:0] contagem
);

   // Plain adder tree over the five input bits.
   always_comb begin
      contagem = 3'd0;
      for (int i = 0; i < N_JOG; i++) begin
         contagem = contagem + {2'b00, bits[i]};
      end
   end

endmodule

// File: rtl/controle_rodada.sv
// Game-round sequencer for the 5-player werewolf board: alternates night and
// day phases, takes one elimination per phase over a valid/ready handshake and
// declares the winner after each elimination.
//
// Handshake: a target transfers on a rising clock edge where alvo_valid and
// alvo_ready are both high; alvo_ready is high only in NOITE and DIA. A
// transferred target is either applied (controller goes to CHECK, ready drops
// for the next cycle) or rejected (erro pulses for one cycle, nothing else
// changes, ready stays high).
module controle_rodada
   import controle_rodada_pkg::*;
#(
   parameter int MAX_RODADAS = 7
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [4:0] lobos,
   input  logic [2:0] alvo,
   input  logic       alvo_valid,
   output logic       alvo_ready,
   output logic       erro,
   output logic [4:0] mortos,
   output logic [2:0] n_mortos,
   output logic [1:0] fase,
   output logic [2:0] rodada,
   output logic [1:0] vencedor,
   output logic       done,
   output logic [2:0] estado_dbg
);

   localparam logic [2:0] MAX_R = 3'(MAX_RODADAS);

   estado_t   estado;
   fase_t     fase_r;
   fase_t     prox_fase;
   vencedor_t vencedor_r;
   logic      inicio;
   logic [4:0] lobos_r;
   logic [4:0] mortos_r;
   logic [2:0] rodada_r;
   logic       erro_r;
   logic       ready_r;

   logic [2:0] lobos_vivos;
   logic [2:0] aldeoes_vivos;
   logic [4:0] mascara_alvo;
   logic       rejeita;
   logic       transfere;

   conta_mortes u_conta_mortos (
      .bits     (mortos_r),
      .contagem (n_mortos)
   );

   conta_mortes u_conta_lobos (
      .bits     (lobos_r & ~mortos_r),
      .contagem (lobos_vivos)
   );

   conta_mortes u_conta_aldeoes (
      .bits     (~lobos_r & ~mortos_r),
      .contagem (aldeoes_vivos)
   );

   // Decode the presented target: one-hot kill mask and rejection flag.
   always_comb begin
      mascara_alvo = 5'd0;
      if (alvo < 3'd5) begin
         mascara_alvo = 5'd1 << alvo;
      end
      rejeita   = alvo_rejeitado(alvo, (estado == EST_NOITE), mortos_r, lobos_r);
      transfere = alvo_valid && ready_r;
   end

   // Round controller: phase sequencing, dead mask, round count and verdict.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado     <= EST_IDLE;
         fase_r     <= FASE_IDLE;
         prox_fase  <= FASE_NOITE;
         vencedor_r <= VENC_NENHUM;
         inicio     <= 1'b0;
         lobos_r    <= 5'd0;
         mortos_r   <= 5'd0;
         rodada_r   <= 3'd0;
         erro_r     <= 1'b0;
         ready_r    <= 1'b0;
      end else begin
         erro_r <= 1'b0;
         case (estado)
            EST_IDLE, EST_FIM: begin
               if (start) begin
                  lobos_r    <= lobos;
                  mortos_r   <= 5'd0;
                  rodada_r   <= 3'd1;
                  vencedor_r <= VENC_NENHUM;
                  prox_fase  <= FASE_NOITE;
                  inicio     <= 1'b1;
                  ready_r    <= 1'b0;
                  estado     <= EST_CHECK;
               end
            end
            EST_NOITE, EST_DIA: begin
               if (transfere) begin
                  if (rejeita) begin
                     erro_r <= 1'b1;
                  end else begin
                     mortos_r  <= mortos_r | mascara_alvo;
                     prox_fase <= (estado == EST_NOITE) ? FASE_DIA : FASE_NOITE;
                     ready_r   <= 1'b0;
                     estado    <= EST_CHECK;
                  end
               end
            end
            EST_CHECK: begin
               inicio <= 1'b0;
               if (lobos_vivos == 3'd0) begin
                  vencedor_r <= VENC_ALDEIA;
                  fase_r     <= FASE_FIM;
                  estado     <= EST_FIM;
               end else if (lobos_vivos >= aldeoes_vivos) begin
                  vencedor_r <= VENC_LOBOS;
                  fase_r     <= FASE_FIM;
                  estado     <= EST_FIM;
               end else if (prox_fase == FASE_NOITE && !inicio) begin
                  // A full day/night cycle has completed: advance or cap the round.
                  if (rodada_r == MAX_R) begin
                     vencedor_r <= VENC_LOBOS;
                     fase_r     <= FASE_FIM;
                     estado     <= EST_FIM;
                  end else begin
                     rodada_r <= rodada_r + 3'd1;
                     fase_r   <= FASE_NOITE;
                     ready_r  <= 1'b1;
                     estado   <= EST_NOITE;
                  end
               end else begin
                  fase_r  <= prox_fase;
                  ready_r <= 1'b1;
                  estado  <= (prox_fase == FASE_NOITE) ? EST_NOITE : EST_DIA;
               end
            end
            default: begin
               estado <= EST_IDLE;
            end
         endcase
      end
   end

   // Output mapping from the registers.
   always_comb begin
      alvo_ready = ready_r;
      erro       = erro_r;
      mortos     = mortos_r;
      fase       = fase_r;
      rodada     = rodada_r;
      vencedor   = vencedor_r;
      done       = (fase_r == FASE_FIM);
      estado_dbg = estado;
   end

endmodule

// File: tb/tb_controle_rodada.sv
// Bench for controle_rodada: directed game scenarios with a scoreboard of
// expected {fase, rodada, vencedor, mortos} snapshots.
module tb_controle_rodada;

   localparam int MAXR = 2;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic [4:0] lobos;
   logic [2:0] alvo;
   logic       alvo_valid;
   logic       alvo_ready;
   logic       erro;
   logic [4:0] mortos;
   logic [2:0] n_mortos;
   logic [1:0] fase;
   logic [2:0] rodada;
   logic [1:0] vencedor;
   logic       done;
   logic [2:0] estado_dbg;

   int n_vec;
   int n_err;
   logic [11:0] exp_q[$];

   controle_rodada #(.MAX_RODADAS(MAXR)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .lobos      (lobos),
      .alvo       (alvo),
      .alvo_valid (alvo_valid),
      .alvo_ready (alvo_ready),
      .erro       (erro),
      .mortos     (mortos),
      .n_mortos   (n_mortos),
      .fase       (fase),
      .rodada     (rodada),
      .vencedor   (vencedor),
      .done       (done),
      .estado_dbg (estado_dbg)
   );

   // Clock/reset block.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [11:0] snap(input logic [1:0] f, input logic [2:0] r,
                                        input logic [1:0] v, input logic [4:0] m);
      return {f, r, v, m};
   endfunction

   function automatic logic [11:0] observado();
      return {fase, rodada, vencedor, mortos};
   endfunction

   task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_vec++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   task automatic checa_saida(input string tag);
      logic [11:0] esp;
      if (exp_q.size() == 0) begin
         confere({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         esp = exp_q.pop_front();
         confere(tag, 32'(observado()), 32'(esp));
      end
   endtask

   task automatic aplica_reset();
      reset_n    = 1'b0;
      start      = 1'b0;
      alvo_valid = 1'b0;
      alvo       = 3'd0;
      lobos      = 5'd0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Start pulse; result is checked two edges later.
   task automatic pulsa_start(input string tag, input logic [4:0] m, input logic [11:0] esp);
      exp_q.push_back(esp);
      @(negedge clock);
      lobos = m;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      checa_saida(tag);
   endtask

   task automatic espera_ready();
      for (int i = 0; i < 8; i++) begin
         if (alvo_ready) break;
         @(negedge clock);
      end
      confere("ready_wait", 32'(alvo_ready), 32'd1);
   endtask

   // Presents one target; esp is the snapshot expected once it has been handled.
   task automatic envia_alvo(input string tag, input logic [2:0] a, input logic rej,
                             input logic [11:0] esp);
      espera_ready();
      exp_q.push_back(esp);
      alvo       = a;
      alvo_valid = 1'b1;
      @(negedge clock);
      alvo_valid = 1'b0;
      confere({tag, "_erro"}, 32'(erro), 32'(rej));
      confere({tag, "_ready"}, 32'(alvo_ready), 32'(rej));
      if (rej) begin
         checa_saida(tag);
         @(negedge clock);
         confere({tag, "_erro_end"}, 32'(erro), 32'd0);
      end else begin
         @(negedge clock);
         checa_saida(tag);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      aplica_reset();

      // Reset state.
      confere("rst_state", 32'(observado()), 32'(snap(2'd0, 3'd0, 2'd0, 5'd0)));
      confere("rst_ready", 32'(alvo_ready), 32'd0);
      confere("rst_erro", 32'(erro), 32'd0);
      confere("rst_done", 32'(done), 32'd0);

      // Village win.
      pulsa_start("vil_start", 5'b00001, snap(2'd1, 3'd1, 2'd0, 5'b00000));
      envia_alvo("vil_night", 3'd1, 1'b0, snap(2'd2, 3'd1, 2'd0, 5'b00010));
      envia_alvo("vil_day", 3'd0, 1'b0, snap(2'd3, 3'd1, 2'd1, 5'b00011));
      confere("vil_nmortos", 32'(n_mortos), 32'd2);
      confere("vil_done", 32'(done), 32'd1);
      repeat (3) @(negedge clock);
      confere("vil_hold", 32'(observado()), 32'(snap(2'd3, 3'd1, 2'd1, 5'b00011)));

      // Restart from FIM with a simultaneous target: start wins.
      exp_q.push_back(snap(2'd1, 3'd1, 2'd0, 5'b00000));
      @(negedge clock);
      lobos      = 5'b00011;
      start      = 1'b1;
      alvo       = 3'd2;
      alvo_valid = 1'b1;
      @(negedge clock);
      start      = 1'b0;
      alvo_valid = 1'b0;
      @(negedge clock);
      checa_saida("restart");

      // Start in NOITE is ignored.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      confere("noite_start_ign", 32'(observado()), 32'(snap(2'd1, 3'd1, 2'd0, 5'b00000)));
      confere("noite_start_rdy", 32'(alvo_ready), 32'd1);

      // Wolf win: 2 wolves vs 2 villagers after the night kill.
      envia_alvo("wolf_night", 3'd2, 1'b0, snap(2'd3, 3'd1, 2'd2, 5'b00100));
      confere("wolf_nmortos", 32'(n_mortos), 32'd1);

      // Rejections.
      pulsa_start("rej_start", 5'b00001, snap(2'd1, 3'd1, 2'd0, 5'b00000));
      envia_alvo("rej_wolf", 3'd0, 1'b1, snap(2'd1, 3'd1, 2'd0, 5'b00000));
      envia_alvo("rej_range", 3'($urandom_range(5, 6)), 1'b1, snap(2'd1, 3'd1, 2'd0, 5'b00000));
      envia_alvo("rej_abst_n", 3'd7, 1'b1, snap(2'd1, 3'd1, 2'd0, 5'b00000));
      envia_alvo("rej_night_ok", 3'd1, 1'b0, snap(2'd2, 3'd1, 2'd0, 5'b00010));
      envia_alvo("rej_dead", 3'd1, 1'b1, snap(2'd2, 3'd1, 2'd0, 5'b00010));
      envia_alvo("rej_range_d", 3'($urandom_range(5, 6)), 1'b1, snap(2'd2, 3'd1, 2'd0, 5'b00010));

      // Abstain and round cap (MAX_RODADAS = 2).
      envia_alvo("cap_abst1", 3'd7, 1'b0, snap(2'd1, 3'd2, 2'd0, 5'b00010));
      envia_alvo("cap_night2", 3'd2, 1'b0, snap(2'd2, 3'd2, 2'd0, 5'b00110));
      envia_alvo("cap_abst2", 3'd7, 1'b0, snap(2'd3, 3'd2, 2'd2, 5'b00110));

      // Asynchronous reset in the middle of DIA.
      pulsa_start("mid_start", 5'b00001, snap(2'd1, 3'd1, 2'd0, 5'b00000));
      envia_alvo("mid_night", 3'd1, 1'b0, snap(2'd2, 3'd1, 2'd0, 5'b00010));
      #2 reset_n = 1'b0;
      #1;
      confere("mid_rst_state", 32'(observado()), 32'(snap(2'd0, 3'd0, 2'd0, 5'd0)));
      confere("mid_rst_ready", 32'(alvo_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Invalid role masks end the game straight away.
      pulsa_start("inv_zero", 5'b00000, snap(2'd3, 3'd1, 2'd1, 5'b00000));
      pulsa_start("inv_many", 5'b00111, snap(2'd3, 3'd1, 2'd2, 5'b00000));

      confere("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
